decode_stage: RTL and testbench

Registered, flow-controlled instruction decode stage for the SCProcessor pipeline. It splits each fetched instruction into opcode, register-specifier and immediate fields. The branch-format operand remap is kept: `op1` of `01xx` means `rs1`/`rs2` come from the `rd`/`rs1` slots. New in this generation: a valid/ready handshake on both sides, a 2-entry skid buffer so back-pressure never drops an instruction, PC passthrough, flush, and a parametrised immediate extension to datapath width. It sits between fetch and register read.

---
 rtl/decode_stage_if.sv | 45 ++++
 rtl/decode_stage.sv | 129 ++++++++++++
 tb/tb_decode_stage.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
//------------------------------------------------------------------------------
// decode_stage_if : fetch-side and downstream-side handshake bundle of the
//                   decode stage.
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface decode_stage_if #(
  parameter int INST_WIDTH = 32,
  parameter int REG_WIDTH  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [INST_WIDTH-1:0] in_inst;
  logic [PC_WIDTH-1:0]   in_pc;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [3:0]            op1;
  logic [3:0]            op2;
  logic [REG_WIDTH-1:0]  rd;
  logic [REG_WIDTH-1:0]  rs1;
  logic [REG_WIDTH-1:0]  rs2;
  logic [15:0]           imm16;
  logic [DATA_WIDTH-1:0] imm_ext;
  logic                  is_branch_fmt;
  logic [PC_WIDTH-1:0]   out_pc;

  // master: fetch + downstream consumer; slave: the decode stage itself
  modport master (
    output in_valid, in_inst, in_pc, flush, out_ready,
    input  in_ready, out_valid, op1, op2, rd, rs1, rs2, imm16, imm_ext,
           is_branch_fmt, out_pc
  );

  modport slave (
    input  in_valid, in_inst, in_pc, flush, out_ready,
    output in_ready, out_valid, op1, op2, rd, rs1, rs2, imm16, imm_ext,
           is_branch_fmt, out_pc
  );
endinterface

`default_nettype wire

// File: rtl/decode_stage.sv
//------------------------------------------------------------------------------
// decode_stage : registered instruction decode with valid/ready flow control
//                and a 2-entry (main + skid) buffer.
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module decode_stage #(
  parameter int INST_WIDTH = 32,
  parameter int REG_WIDTH  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32,
  parameter bit IMM_SIGNED = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  decode_stage_if.slave bus
);
  localparam int c_bw = 8 + 3*REG_WIDTH + 16 + PC_WIDTH;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_in_ready;
  logic [c_bw-1:0] r_main;
  logic [c_bw-1:0] r_skid;
  logic [c_bw-1:0] w_dec;
  logic            w_accept;
  logic            w_xfer;
  logic            w_out_valid;
  logic            w_load_main_in;
  logic            w_load_main_skid;
  logic            w_load_skid;
  logic [31:0]     w_inst;
  logic [15:0]     w_main_imm16;

  assign w_inst = bus.in_inst[31:0];

  // Branch format (op1 = 01xx) shifts the source specifiers up one slot
  assign w_dec = {w_inst[31:28],
                  w_inst[27:24],
                  REG_WIDTH'(w_inst[23:20]),
                  REG_WIDTH'(w_inst[30] ? w_inst[23:20] : w_inst[19:16]),
                  REG_WIDTH'(w_inst[30] ? w_inst[19:16] : w_inst[15:12]),
                  w_inst[15:0],
                  bus.in_pc};

  assign w_out_valid = (r_state != EMPTY);
  assign w_accept    = bus.in_valid && r_in_ready;
  assign w_xfer      = w_out_valid && bus.out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_state_nxt    = ONE;
          w_load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (w_accept && w_xfer) begin
          w_load_main_in = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = FULL;
          w_load_skid = 1'b1;
        end else if (w_xfer) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so no accept can coincide with the drain
        if (w_xfer) begin
          w_state_nxt      = ONE;
          w_load_main_skid = 1'b1;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
    if (bus.flush) begin
      w_state_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
      r_main     <= '0;
      r_skid     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != FULL);
      if (w_load_main_in) begin
        r_main <= w_dec;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_dec;
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = w_out_valid;
  assign {bus.op1, bus.op2, bus.rd, bus.rs1, bus.rs2, w_main_imm16, bus.out_pc} = r_main;
  assign bus.imm16         = w_main_imm16;
  assign bus.is_branch_fmt = r_main[c_bw-2];

  generate
    if (IMM_SIGNED) begin : g_sext
      assign bus.imm_ext = DATA_WIDTH'($signed(w_main_imm16));
    end else begin : g_zext
      assign bus.imm_ext = DATA_WIDTH'(w_main_imm16);
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
//------------------------------------------------------------------------------
// tb_decode_stage : directed bench for decode_stage (signed and unsigned
//                   immediate variants driven from one stimulus stream).
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_decode_stage;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  decode_stage_if #(.INST_WIDTH(32), .REG_WIDTH(4), .DATA_WIDTH(32), .PC_WIDTH(32)) bus ();
  decode_stage_if #(.INST_WIDTH(32), .REG_WIDTH(4), .DATA_WIDTH(32), .PC_WIDTH(32)) bus0 ();

  decode_stage #(.INST_WIDTH(32), .REG_WIDTH(4), .DATA_WIDTH(32), .PC_WIDTH(32),
                 .IMM_SIGNED(1'b1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  decode_stage #(.INST_WIDTH(32), .REG_WIDTH(4), .DATA_WIDTH(32), .PC_WIDTH(32),
                 .IMM_SIGNED(1'b0)) u_dut_zext (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  assign bus0.in_valid  = bus.in_valid;
  assign bus0.in_inst   = bus.in_inst;
  assign bus0.in_pc     = bus.in_pc;
  assign bus0.flush     = bus.flush;
  assign bus0.out_ready = bus.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
    bus.in_valid = v;
    bus.in_inst  = inst;
    bus.in_pc    = pc;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    tick();

    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_op1",       64'(bus.op1),       64'd0);
    check("rst_imm_ext",   64'(bus.imm_ext),   64'd0);
    check("rst_out_pc",    64'(bus.out_pc),    64'd0);

    // basic decode
    reset = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h1234_5678, 32'h0000_0100);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    check("basic_valid",  64'(bus.out_valid),     64'd1);
    check("basic_op1",    64'(bus.op1),           64'h1);
    check("basic_op2",    64'(bus.op2),           64'h2);
    check("basic_rd",     64'(bus.rd),            64'h3);
    check("basic_rs1",    64'(bus.rs1),           64'h4);
    check("basic_rs2",    64'(bus.rs2),           64'h5);
    check("basic_imm",    64'(bus.imm_ext),       64'h0000_5678);
    check("basic_br",     64'(bus.is_branch_fmt), 64'd0);
    check("basic_pc",     64'(bus.out_pc),        64'h100);
    tick();
    check("basic_drain",  64'(bus.out_valid),     64'd0);

    // branch format, both immediate extensions
    drive(1'b1, 32'h4A3B_8001, 32'h0000_0140);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    check("br_op1",       64'(bus.op1),           64'h4);
    check("br_op2",       64'(bus.op2),           64'hA);
    check("br_rd",        64'(bus.rd),            64'h3);
    check("br_rs1",       64'(bus.rs1),           64'h3);
    check("br_rs2",       64'(bus.rs2),           64'hB);
    check("br_imm16",     64'(bus.imm16),         64'h8001);
    check("br_imm_sext",  64'(bus.imm_ext),       64'hFFFF_8001);
    check("br_imm_zext",  64'(bus0.imm_ext),      64'h0000_8001);
    check("br_flag",      64'(bus.is_branch_fmt), 64'd1);
    tick();

    // back-pressure: A, B accepted, C refused until drain begins
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h1000_000A, 32'h200);
    tick();
    check("bp_ready_one", 64'(bus.in_ready), 64'd1);
    drive(1'b1, 32'h2000_000B, 32'h204);
    tick();
    check("bp_ready_full", 64'(bus.in_ready), 64'd0);
    drive(1'b1, 32'h3000_000C, 32'h208);
    tick();
    check("bp_hold_pc",   64'(bus.out_pc),    64'h200);
    check("bp_hold_imm",  64'(bus.imm16),     64'h000A);
    check("bp_still_full", 64'(bus.in_ready), 64'd0);
    tick();
    check("bp_hold_pc2",  64'(bus.out_pc),    64'h200);
    bus.out_ready = 1'b1;
    tick();
    check("bp_b_pc",      64'(bus.out_pc),    64'h204);
    check("bp_b_op1",     64'(bus.op1),       64'h2);
    check("bp_ready_rel", 64'(bus.in_ready),  64'd1);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    check("bp_c_pc",      64'(bus.out_pc),    64'h208);
    check("bp_c_valid",   64'(bus.out_valid), 64'd1);
    tick();
    check("bp_empty",     64'(bus.out_valid), 64'd0);

    // flush while FULL with an input presented
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h1000_0001, 32'h300);
    tick();
    drive(1'b1, 32'h1000_0002, 32'h304);
    tick();
    drive(1'b1, 32'h1000_0003, 32'h308);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("fl_valid",     64'(bus.out_valid), 64'd0);
    check("fl_ready",     64'(bus.in_ready),  64'd1);
    bus.out_ready = 1'b1;
    tick();
    check("fl_no_ghost",  64'(bus.out_valid), 64'd0);

    // flush from EMPTY discards the input accepted in that cycle
    drive(1'b1, 32'h5000_0005, 32'h380);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("fl_accept_drop", 64'(bus.out_valid), 64'd0);

    // throughput: 8 back-to-back, each visible the cycle after its accept
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h1000_0000 | 32'(i), 32'h400 + 32'(4*i));
      tick();
      check("tp_valid", 64'(bus.out_valid), 64'd1);
      check("tp_pc",    64'(bus.out_pc),    64'h400 + 64'(4*i));
      check("tp_ready", 64'(bus.in_ready),  64'd1);
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("tp_drain", 64'(bus.out_valid), 64'd0);

    // reset while FULL
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h4A3B_8001, 32'h500);
    tick();
    drive(1'b1, 32'h1234_5678, 32'h504);
    tick();
    check("rf_full", 64'(bus.in_ready), 64'd0);
    drive(1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    bus.flush = 1'b1;
    tick();
    reset = 1'b0;
    bus.flush = 1'b0;
    check("rf_valid",   64'(bus.out_valid), 64'd0);
    check("rf_ready",   64'(bus.in_ready),  64'd1);
    check("rf_op1",     64'(bus.op1),       64'd0);
    check("rf_rd",      64'(bus.rd),        64'd0);
    check("rf_rs1",     64'(bus.rs1),       64'd0);
    check("rf_imm_ext", 64'(bus.imm_ext),   64'd0);
    check("rf_br",      64'(bus.is_branch_fmt), 64'd0);
    check("rf_pc",      64'(bus.out_pc),    64'd0);
    bus.out_ready = 1'b1;
    tick();
    check("rf_skid_gone", 64'(bus.out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
